id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold control and a saturating stall counter.
// Define ID_EX_HAZARD_DETECT_EN to enable the load-use detector; without it, bubbles come only from flush_i or id_valid=0.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic          id_regds,
  input  logic          id_branch,
  input  logic          id_mread,
  input  logic          id_mtor,
  input  logic          id_mwrite,
  input  logic          id_alusrc,
  input  logic          id_urw,
  input  logic [2:0]    id_aop,
  input  logic [DW-1:0] id_rd1,
  input  logic [DW-1:0] id_rd2,
  input  logic [DW-1:0] id_imm,
  input  logic [DW-1:0] id_pc4,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic [4:0]    id_rd,
  input  logic          flush_i,
  input  logic          hold_i,
  output logic          ex_valid,
  output logic          ex_regds,
  output logic          ex_branch,
  output logic          ex_mread,
  output logic          ex_mtor,
  output logic          ex_mwrite,
  output logic          ex_alusrc,
  output logic          ex_urw,
  output logic [2:0]    ex_aop,
  output logic [DW-1:0] ex_rd1,
  output logic [DW-1:0] ex_rd2,
  output logic [DW-1:0] ex_imm,
  output logic [DW-1:0] ex_pc4,
  output logic [4:0]    ex_rs,
  output logic [4:0]    ex_rt,
  output logic [4:0]    ex_rd,
  output logic          stall_o,
  output logic [CW-1:0] stall_cnt
);

  typedef struct packed {
    logic       regds;
    logic       branch;
    logic       mread;
    logic       mtor;
    logic       mwrite;
    logic       alusrc;
    logic       urw;
    logic [2:0] aop;
  } ctrl_t;

  typedef enum logic {RUN, BUBBLE} state_t;

  state_t state;
  ctrl_t  id_ctrl;
  ctrl_t  ex_ctrl;
  logic   hazard;
  logic   bubble_hazard;

  // Control bits of a non-instruction are forced to zero so an undecoded opcode never reaches EX.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    id_ctrl = '0;
    if (id_valid) begin
      id_ctrl.regds  = id_regds;
      id_ctrl.branch = id_branch;
      id_ctrl.mread  = id_mread;
      id_ctrl.mtor   = id_mtor;
      id_ctrl.mwrite = id_mwrite;
      id_ctrl.alusrc = id_alusrc;
      id_ctrl.urw    = id_urw;
      id_ctrl.aop    = id_aop;
    end
  end

`ifdef ID_EX_HAZARD_DETECT_EN
  logic uses_rt;
  assign uses_rt = ~id_alusrc | id_mwrite | id_branch;
  assign hazard  = ex_valid & ex_mread & (ex_rt != 5'd0) &
                   ((ex_rt == id_rs) | ((ex_rt == id_rt) & uses_rt)) & id_valid;
`else
  assign hazard  = 1'b0;
`endif

  // A bubble clears ex_mread, so in BUBBLE the same load can never stall twice; the state term makes that explicit.
  assign bubble_hazard = hazard & (state == RUN);
  assign stall_o       = bubble_hazard & ~hold_i & ~flush_i;

  assign ex_regds  = ex_ctrl.regds;
  assign ex_branch = ex_ctrl.branch;
  assign ex_mread  = ex_ctrl.mread;
  assign ex_mtor   = ex_ctrl.mtor;
  assign ex_mwrite = ex_ctrl.mwrite;
  assign ex_alusrc = ex_ctrl.alusrc;
  assign ex_urw    = ex_ctrl.urw;
  assign ex_aop    = ex_ctrl.aop;

  // Priority: flush, then hold, then load-use bubble, then normal capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state     <= RUN;
      ex_valid  <= 1'b0;
      ex_ctrl   <= '0;
      ex_rd1    <= '0;
      ex_rd2    <= '0;
      ex_imm    <= '0;
      ex_pc4    <= '0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_rd     <= '0;
      stall_cnt <= '0;
    end else if (flush_i) begin
      state    <= RUN;
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end else if (!hold_i) begin
      if (bubble_hazard) begin
        state    <= BUBBLE;
        ex_valid <= 1'b0;
        ex_ctrl  <= '0;
        if (stall_cnt != '1) stall_cnt <= stall_cnt + CW'(1);
      end else begin
        state    <= RUN;
        ex_valid <= id_valid;
        ex_ctrl  <= id_ctrl;
        ex_rd1   <= id_rd1;
        ex_rd2   <= id_rd2;
        ex_imm   <= id_imm;
        ex_pc4   <= id_pc4;
        ex_rs    <= id_rs;
        ex_rt    <= id_rt;
        ex_rd    <= id_rd;
      end
    end
  end

endmodule
